fp_product_assembler: RTL and testbench

//  Downstream stage of the FP multiplier mantissa datapath. Merges the three partial

---
 rtl/fp_product_assembler_if.sv | 33 +++
 rtl/fp_product_assembler.sv | 190 +++++++++++++++++++
 tb/tb_fp_product_assembler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fp_product_assembler_if.sv
// Handshake and operand/result bundle for the FP product assembler.
// master drives operands and out_ready; slave is the assembler.
interface fp_product_assembler_if #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     sign_a;
  logic                     sign_b;
  logic [EXP_W-1:0]         exp_a;
  logic [EXP_W-1:0]         exp_b;
  logic [SIG_W-1:0]         hi_prod;
  logic [2*SIG_W-1:0]       mid_sum;
  logic [SIG_W-1:0]         lo_prod;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+SIG_W-1:0]   result;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output in_valid, sign_a, sign_b, exp_a, exp_b,
    output hi_prod, mid_sum, lo_prod, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, sign_a, sign_b, exp_a, exp_b,
    input  hi_prod, mid_sum, lo_prod, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_product_assembler.sv
// Merges split partial products, normalizes, rounds to nearest
// even and packs a {sign, exp, frac} float over a 3-stage pipe.
module fp_product_assembler #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  fp_product_assembler_if.slave bus
);
  localparam int PW   = 2 * SIG_W;
  localparam int FR_W = SIG_W - 1;
  localparam int EW   = EXP_W + 2;
  localparam int RW   = EXP_W + SIG_W;
  localparam logic [EW-1:0] BIAS =
    EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX =
    EW'((1 << EXP_W) - 1);
  localparam logic [RW-1:0] NAN_Q =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FR_W-1){1'b0}}};

  logic            w_stall;
  logic            w_adv;
  logic            w_acc;
  logic [PW+1:0]   w_p;
  logic [EW-1:0]   w_e1;
  logic            w_zero;
  logic            w_inf;

  logic            r_s1_v;
  logic [PW-1:0]   r_s1_p;
  logic            r_s1_s;
  logic [EW-1:0]   r_s1_e;
  logic            r_s1_zero;
  logic            r_s1_inf;
  logic            r_s1_nan;

  logic [FR_W-1:0] w_frac2;
  logic            w_g;
  logic            w_st;
  logic [EW-1:0]   w_e2;
  logic            w_inc;

  logic            r_s2_v;
  logic [FR_W-1:0] r_s2_frac;
  logic            r_s2_inc;
  logic [EW-1:0]   r_s2_e;
  logic            r_s2_s;
  logic            r_s2_zero;
  logic            r_s2_inf;
  logic            r_s2_nan;

  logic [FR_W:0]   w_sum;
  logic [FR_W-1:0] w_frac3;
  logic [EW-1:0]   w_e3;
  logic [RW-1:0]   w_res;
  logic            w_ovf;
  logic            w_unf;

  logic            r_s3_v;
  logic [RW-1:0]   r_result;
  logic            r_ovf;
  logic            r_unf;

  assign w_stall = r_s3_v & ~bus.out_ready;
  assign w_adv   = ~w_stall;
  assign w_acc   = bus.in_valid & w_adv;

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_s3_v;
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

  assign w_p = (PW+2)'({bus.hi_prod, {SIG_W{1'b0}}})
             + ((PW+2)'(bus.mid_sum) << (SIG_W / 2))
             + (PW+2)'(bus.lo_prod);
  assign w_e1 = EW'(bus.exp_a) + EW'(bus.exp_b) - BIAS;
  assign w_zero = (bus.exp_a == '0) | (bus.exp_b == '0);
  assign w_inf  = (&bus.exp_a) | (&bus.exp_b);

  // S1: capture merged product, exponent sum and class
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_p    <= '0;
      r_s1_s    <= 1'b0;
      r_s1_e    <= '0;
      r_s1_zero <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_nan  <= 1'b0;
    end else if (w_adv) begin
      r_s1_v    <= bus.in_valid;
      r_s1_p    <= w_p[PW-1:0];
      r_s1_s    <= bus.sign_a ^ bus.sign_b;
      r_s1_e    <= w_e1;
      r_s1_zero <= w_zero;
      r_s1_inf  <= w_inf;
      r_s1_nan  <= w_zero & w_inf;
    end
  end

  // S2 normalize: product lies in [1,4), pick the leading bit
  always_comb begin
    w_frac2 = r_s1_p[PW-3 -: FR_W];
    w_g     = r_s1_p[PW-3-FR_W];
    w_st    = |r_s1_p[PW-4-FR_W:0];
    w_e2    = r_s1_e;
    if (r_s1_p[PW-1]) begin
      w_frac2 = r_s1_p[PW-2 -: FR_W];
      w_g     = r_s1_p[PW-2-FR_W];
      w_st    = |r_s1_p[PW-3-FR_W:0];
      w_e2    = r_s1_e + EW'(1);
    end
    w_inc = w_g & (w_st | w_frac2[0]);
  end

  // S2: capture normalized fraction and rounding decision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_frac <= '0;
      r_s2_inc  <= 1'b0;
      r_s2_e    <= '0;
      r_s2_s    <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_inf  <= 1'b0;
      r_s2_nan  <= 1'b0;
    end else if (w_adv) begin
      r_s2_v    <= r_s1_v;
      r_s2_frac <= w_frac2;
      r_s2_inc  <= w_inc;
      r_s2_e    <= w_e2;
      r_s2_s    <= r_s1_s;
      r_s2_zero <= r_s1_zero;
      r_s2_inf  <= r_s1_inf;
      r_s2_nan  <= r_s1_nan;
    end
  end

  // S3 round, then special classes before range checks
  always_comb begin
    w_sum   = {1'b0, r_s2_frac} + (FR_W+1)'(r_s2_inc);
    w_frac3 = w_sum[FR_W-1:0];
    w_e3    = r_s2_e;
    if (w_sum[FR_W]) begin
      w_frac3 = '0;
      w_e3    = r_s2_e + EW'(1);
    end
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_res = {r_s2_s, w_e3[EXP_W-1:0], w_frac3};
    if (r_s2_nan) begin
      w_res = NAN_Q;
    end else if (r_s2_inf) begin
      w_res = {r_s2_s, {EXP_W{1'b1}}, {FR_W{1'b0}}};
    end else if (r_s2_zero) begin
      w_res = {r_s2_s, {(RW-1){1'b0}}};
    end else if ($signed(w_e3) >= $signed(EMAX)) begin
      w_res = {r_s2_s, {EXP_W{1'b1}}, {FR_W{1'b0}}};
      w_ovf = 1'b1;
    end else if ($signed(w_e3) <= $signed(EW'(0))) begin
      w_res = {r_s2_s, {(RW-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  // S3: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_v   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (w_adv) begin
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  a_norm_in: assert property (
    @(posedge clk) disable iff (rst)
    (w_acc && !w_zero && !w_inf) |->
      (w_p[PW+1:PW] == 2'b00 && w_p[PW-1:PW-2] != 2'b00)
  );
endmodule

// File: tb/tb_fp_product_assembler.sv
// Directed bench for fp_product_assembler: arithmetic vectors,
// exception classes, backpressure stream and mid-flight reset.
module tb_fp_product_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_product_assembler_if bus ();

  fp_product_assembler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sa, input logic sb,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [15:0] hi,
                       input logic [31:0] mid,
                       input logic [15:0] lo);
    bus.sign_a  = sa;
    bus.sign_b  = sb;
    bus.exp_a   = ea;
    bus.exp_b   = eb;
    bus.hi_prod = hi;
    bus.mid_sum = mid;
    bus.lo_prod = lo;
  endtask

  task automatic run_vec(input string tag,
                         input logic sa, input logic sb,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [15:0] hi,
                         input logic [31:0] mid,
                         input logic [15:0] lo,
                         input logic [23:0] er,
                         input logic eo, input logic eu);
    int lat;
    bus.out_ready = 1'b1;
    drive(sa, sb, ea, eb, hi, mid, lo);
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/lat"}, 32'(lat), 32'd3);
    chk({tag, "/res"}, 32'(bus.result), 32'(er));
    chk({tag, "/ovf"}, 32'(bus.overflow), 32'(eo));
    chk({tag, "/unf"}, 32'(bus.underflow), 32'(eu));
    @(negedge clk);
    chk({tag, "/drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [23:0] q[$];
  logic [23:0] exp_r;
  int sent;
  int got;
  int seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 16'd0, 32'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst/ov", 32'(bus.out_valid), 32'd0);
    chk("rst/res", 32'(bus.result), 32'd0);
    chk("rst/ovf", 32'(bus.overflow), 32'd0);
    chk("rst/unf", 32'(bus.underflow), 32'd0);
    chk("rst/ir", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    run_vec("one", 0, 0, 8'd127, 8'd127, 16'h4000, 32'h0,
            16'h0000, 24'h3F8000, 0, 0);
    run_vec("p31", 0, 0, 8'd127, 8'd127, 16'h9000, 32'h0,
            16'h0000, 24'h401000, 0, 0);
    run_vec("rne_up", 0, 0, 8'd127, 8'd127, 16'h4000, 32'h0,
            16'hC000, 24'h3F8002, 0, 0);
    run_vec("rne_tie", 0, 0, 8'd127, 8'd127, 16'h4000, 32'h0,
            16'h4000, 24'h3F8000, 0, 0);
    run_vec("mid", 0, 0, 8'd127, 8'd127, 16'h4000, 32'h100,
            16'h0000, 24'h3F8002, 0, 0);
    run_vec("carry", 0, 0, 8'd127, 8'd127, 16'h7FFF, 32'h0,
            16'hC000, 24'h400000, 0, 0);
    run_vec("neg", 0, 1, 8'd127, 8'd127, 16'h4000, 32'h0,
            16'h0000, 24'hBF8000, 0, 0);
    run_vec("ovf", 1, 0, 8'hF0, 8'hF0, 16'h4000, 32'h0,
            16'h0000, 24'hFF8000, 1, 0);
    run_vec("unf", 0, 0, 8'd40, 8'd40, 16'h4000, 32'h0,
            16'h0000, 24'h000000, 0, 1);
    run_vec("e0", 0, 0, 8'd64, 8'd63, 16'h4000, 32'h0,
            16'h0000, 24'h000000, 0, 1);
    run_vec("e254", 0, 0, 8'd254, 8'd127, 16'h4000, 32'h0,
            16'h0000, 24'h7F0000, 0, 0);
    run_vec("e255", 0, 0, 8'd254, 8'd127, 16'h9000, 32'h0,
            16'h0000, 24'h7F8000, 1, 0);
    run_vec("nan", 1, 0, 8'hFF, 8'h00, 16'h4000, 32'h0,
            16'h0000, 24'h7FC000, 0, 0);
    run_vec("inf", 1, 1, 8'hFF, 8'd128, 16'h4000, 32'h0,
            16'h0000, 24'h7F8000, 0, 0);
    run_vec("zero", 1, 0, 8'h00, 8'd128, 16'h0000, 32'h0,
            16'h0000, 24'h800000, 0, 0);

    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      bus.out_ready = !(c >= 4 && c < 9);
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("bp/extra", 32'd1, 32'd0);
        end else begin
          chk("bp/res", 32'(bus.result), 32'(q[0]));
          if (!bus.out_ready) begin
            chk("bp/stall", 32'(bus.in_ready), 32'd0);
          end else begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (sent < 6) begin
        drive(sent[0], 1'b0, 8'd127, 8'(100 + sent),
              16'h4000, 32'h0, 16'h0);
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          exp_r = {sent[0], 8'(100 + sent), 15'd0};
          q.push_back(exp_r);
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp/sent", 32'(sent), 32'd6);
    chk("bp/count", 32'(got), 32'd6);
    @(negedge clk);
    chk("bp/idle", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'd127, 8'(110 + i),
            16'h4000, 32'h0, 16'h0);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("rstf/pre", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstf/ov", 32'(bus.out_valid), 32'd0);
    chk("rstf/res", 32'(bus.result), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rstf/none", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
